// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - 32 x W register file fed through a one-entry pending write buffer
// Register 0 is hardwired to zero; commits are reported with a registered done pulse.
module regfile_writer #(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [4:0]      wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            stall,
  output logic [32*W-1:0] reg_flat,
  output logic            wr_done,
  output logic [4:0]      wr_done_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]   state;
  logic [4:0]   pend_addr;
  logic [W-1:0] pend_data;
  logic         accept;
  logic         commit;

  // A draining buffer frees its slot on the same edge, giving one write per cycle.
  assign wr_ready = (state == IDLE) || !stall;
  assign accept   = wr_valid && wr_ready;
  assign commit   = (state == PEND) && !stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (accept) begin
      state     <= PEND;
      pend_addr <= wr_addr;
      pend_data <= wr_data;
    end else if (commit) begin
      state     <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_done      <= 1'b0;
      wr_done_addr <= '0;
    end else begin
      wr_done <= commit;
      if (commit) begin
        wr_done_addr <= pend_addr;
      end
    end
  end

  assign reg_flat[W-1:0] = '0;

  for (genvar k = 1; k < 32; k++) begin : g_reg
    logic [W-1:0] q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q <= '0;
      end else if (commit && (pend_addr == 5'(k))) begin
        q <= pend_data;
      end
    end

    assign reg_flat[k*W +: W] = q;
  end

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - scoreboard bench for regfile_writer
module tb_regfile_writer;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            wr_valid;
  logic            wr_ready;
  logic [4:0]      wr_addr;
  logic [W-1:0]    wr_data;
  logic            stall;
  logic [32*W-1:0] reg_flat;
  logic            wr_done;
  logic [4:0]      wr_done_addr;

  typedef struct {
    logic [4:0]   a;
    logic [W-1:0] d;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] model[32];
  logic [4:0]   last_done;
  int           done_count;
  int           vectors;
  int           miscompares;

  regfile_writer #(.W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .stall        (stall),
    .reg_flat     (reg_flat),
    .wr_done      (wr_done),
    .wr_done_addr (wr_done_addr)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: pops one expected commit per wr_done and tracks the whole register image.
  always @(negedge clk) begin
    logic [32*W-1:0] exp_flat;
    ent_t e;
    if (wr_done) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: wr_done=1 addr=%0d, required no commit", wr_done_addr);
      end else begin
        e = q.pop_front();
        if (e.a != 5'd0) model[e.a] = e.d;
        last_done = e.a;
        done_count++;
        if (wr_done_addr !== e.a) begin
          miscompares++;
          $display("FAIL done_addr: got %0d, required %0d", wr_done_addr, e.a);
        end
      end
    end else begin
      vectors++;
      if (wr_done_addr !== last_done) begin
        miscompares++;
        $display("FAIL done_addr_hold: got %0d, required %0d", wr_done_addr, last_done);
      end
    end
    for (int k = 0; k < 32; k++) exp_flat[k*W +: W] = model[k];
    vectors++;
    if (reg_flat !== exp_flat) begin
      miscompares++;
      for (int k = 0; k < 32; k++)
        if (reg_flat[k*W +: W] !== exp_flat[k*W +: W])
          $display("FAIL reg_image: reg%0d got %h, required %h", k, reg_flat[k*W +: W], exp_flat[k*W +: W]);
    end
  end

  task automatic clear_model();
    q.delete();
    for (int k = 0; k < 32; k++) model[k] = '0;
    last_done = '0;
  endtask

  task automatic send(input logic [4:0] a, input logic [W-1:0] d, output int waited);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    waited   = 0;
    #1;
    while (!wr_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!wr_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: wr_ready=%b after %0d cycles, required 1", wr_ready, waited);
    end else begin
      q.push_back('{a: a, d: d});
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    stall    = 1'b0;
    clear_model();
    #1;
    vectors++;
    if (reg_flat !== '0 || wr_done !== 1'b0 || wr_done_addr !== 5'd0 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: flat_nonzero=%b done=%b done_addr=%0d ready=%b, required 0 0 0 1",
               |reg_flat, wr_done, wr_done_addr, wr_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, required 1", wr_ready);
    end
  endtask

  task automatic test_single();
    int w;
    logic [32*W-1:0] exp_flat;
    exp_flat = '0;
    exp_flat[5*W +: W] = 32'hDEADBEEF;
    send(5'd5, 32'hDEADBEEF, w);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    vectors++;
    if (wr_done !== 1'b0 || reg_flat[5*W +: W] !== 32'h0) begin
      miscompares++;
      $display("FAIL single_early: done=%b reg5=%h, required 0 00000000", wr_done, reg_flat[5*W +: W]);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (wr_done !== 1'b1 || wr_done_addr !== 5'd5 || reg_flat !== exp_flat) begin
      miscompares++;
      $display("FAIL single_commit: done=%b addr=%0d reg5=%h others_ok=%b, required 1 5 deadbeef 1",
               wr_done, wr_done_addr, reg_flat[5*W +: W], reg_flat === exp_flat);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (wr_done !== 1'b0 || wr_done_addr !== 5'd5) begin
      miscompares++;
      $display("FAIL single_pulse: done=%b addr=%0d, required 0 5", wr_done, wr_done_addr);
    end
  endtask

  task automatic test_streaming();
    int w;
    int start = done_count;
    for (int a = 1; a < 32; a++) begin
      send(5'(a), 32'(a) * 32'h11111111, w);
      vectors++;
      if (w != 0) begin
        miscompares++;
        $display("FAIL stream_ready: addr %0d waited %0d cycles, required 0", a, w);
      end
    end
    idle();
    drain();
    vectors++;
    if (done_count - start != 31) begin
      miscompares++;
      $display("FAIL stream_pulses: got %0d, required 31", done_count - start);
    end
    for (int k = 1; k < 32; k++) begin
      vectors++;
      if (reg_flat[k*W +: W] !== 32'(k) * 32'h11111111) begin
        miscompares++;
        $display("FAIL stream_reg: reg%0d got %h, required %h", k, reg_flat[k*W +: W], 32'(k) * 32'h11111111);
      end
    end
  endtask

  task automatic test_stall();
    int w;
    stall = 1'b0;
    send(5'd3, 32'hA5A5A5A5, w);
    @(negedge clk);
    wr_valid = 1'b0;
    stall    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (wr_ready !== 1'b0 || wr_done !== 1'b0 || reg_flat[3*W +: W] !== 32'h33333333) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d ready=%b done=%b reg3=%h, required 0 0 33333333",
                 i, wr_ready, wr_done, reg_flat[3*W +: W]);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (wr_done !== 1'b1 || reg_flat[3*W +: W] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL stall_release: done=%b reg3=%h, required 1 a5a5a5a5", wr_done, reg_flat[3*W +: W]);
    end
    drain();
  endtask

  task automatic test_stall_idle();
    int w;
    stall = 1'b1;
    send(5'd11, 32'hCAFEF00D, w);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL stall_idle_ready: waited %0d cycles, required 0", w);
    end
    idle();
    stall = 1'b0;
    drain();
  endtask

  task automatic test_zero();
    int w;
    send(5'd0, 32'hFFFFFFFF, w);
    idle();
    drain();
    @(negedge clk);
    #1;
    vectors++;
    if (reg_flat[W-1:0] !== 32'h0 || wr_done_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL zero_reg: reg0=%h done_addr=%0d, required 00000000 0", reg_flat[W-1:0], wr_done_addr);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int start = done_count;
    send(5'd9, 32'h1, w);
    send(5'd9, 32'h2, w);
    idle();
    drain();
    vectors++;
    if (reg_flat[9*W +: W] !== 32'h2 || done_count - start != 2) begin
      miscompares++;
      $display("FAIL same_addr: reg9=%h pulses=%0d, required 00000002 2", reg_flat[9*W +: W], done_count - start);
    end
  endtask

  task automatic test_reset_midop();
    int w;
    stall = 1'b0;
    send(5'd7, 32'h12345678, w);
    @(negedge clk);
    wr_valid = 1'b0;
    stall    = 1'b1;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    clear_model();
    #1;
    vectors++;
    if (reg_flat !== '0 || wr_done !== 1'b0 || wr_done_addr !== 5'd0 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midop: flat_nonzero=%b done=%b addr=%0d ready=%b, required 0 0 0 1",
               |reg_flat, wr_done, wr_done_addr, wr_ready);
    end
    #1;
    reset_n = 1'b1;
    stall   = 1'b0;
    #1;
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_midop_reset: got %b, required 1", wr_ready);
    end
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (reg_flat[7*W +: W] !== 32'h0) begin
      miscompares++;
      $display("FAIL discarded_write: reg7=%h, required 00000000", reg_flat[7*W +: W]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_count  = 0;
    test_reset();
    test_single();
    test_streaming();
    test_stall();
    test_stall_idle();
    test_zero();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
